codec_mm_slave: RTL and testbench
=================================

// Module: codec_mm_slave
// PURPOSE
//  Parametrised Avalon-MM slave, next generation of the WM8731 codec register interface.
//  Maps the I2C command, status, DAC FIFO and ADC FIFO onto the bus and adds backpressure
//  (waitrequest), fixed-address burst transfers and maskable sticky interrupts.
//  Sits between the Nios/Avalon fabric and the codec I2C master and the audio FIFOs.
// PARAMETERS
//  SAMPLE_W  16  bits per audio sample
//  NUM_CH     2  audio channels packed per bus word; DATA_W = NUM_CH*SAMPLE_W (localparam, <=32)
//  I2C_W     24  I2C packet width (addr+reg+data)
//  BURST_W    8  width of slave_burstcount
// PORTS
//  Clk               in   1        system clock
//  Rst               in   1        asynchronous reset, active high
//  slave_chipselect  in   1        access valid when high
//  slave_read        in   1        read request
//  slave_write       in   1        write request
//  slave_address     in   3        word address (map in BEHAVIOUR)
//  slave_writedata   in   32       write bus
//  slave_readdata    out  32       read bus, combinational, 0 when no valid read
//  slave_waitrequest out  1        stall current access
//  slave_beginbursttransfer in 1   first beat of a burst
//  slave_burstcount  in   BURST_W  beats in burst
//  slave_irq         out  1        level interrupt
//  i2c_idle          in   1        I2C master ready
//  i2c_start         out  1        1-cycle pulse: i2c_packet valid
//  i2c_packet        out  I2C_W    last written I2C command
//  dac_fifo_full     in   1        DAC FIFO full
//  dac_wr            out  1        1-cycle push strobe
//  dac_fifo_in       out  DATA_W   push data = slave_writedata[DATA_W-1:0]
//  adc_fifo_empty    in   1        ADC FIFO empty
//  adc_rd            out  1        1-cycle pop strobe (show-ahead FIFO)
//  adc_fifo_out      in   DATA_W   ADC FIFO head word
// BEHAVIOUR
//  Reset: all outputs 0, i2c_packet 0, burst FSM IDLE, bCount 0, mask/pending 0.
//  Map: 0 I2C_CMD RW | 1 STATUS RO {pend[2:0],adc_fifo_empty,dac_fifo_full,i2c_idle} | 2 DAC WO
//       3 ADC RO | 4 IRQ_MASK RW [2:0] | 5 IRQ_PEND RW1C [2:0] | 6,7 read 0, write ignored.
//  Beat accepted = chipselect & (read^write) & !waitrequest; zero-latency read, readdata combinational.
//  waitrequest = cs&write&(addr0&!i2c_idle | addr2&dac_fifo_full) | cs&read&addr3&adc_fifo_empty.
//  Accepted write addr0: register low I2C_W bits, i2c_start pulse next cycle.
//  Accepted write addr2: dac_wr same cycle, dac_fifo_in = writedata. Accepted read addr3: adc_rd same cycle.
//  read&write both high: no access, waitrequest 0, no strobes.
//  Burst FSM IDLE/RD/WR: in IDLE, beginburst & read-only -> RD, write-only -> WR; burstcount
//   loads bCount and the address is latched. Burstcount 0 or both strobes -> stay IDLE.
//   bCount decrements per accepted beat (first beat included). Accepted beat at bCount==1 -> IDLE.
//   In RD/WR the latched address overrides slave_address (fixed-address FIFO bursts).
//   A stalled beat (waitrequest) does not decrement. Reset mid-burst -> IDLE, no strobe.
// CONFIGURATION
//  CODEC_MM_SLAVE_IRQ_EN defined: pend bits set on rising edge of i2c_idle(0), !dac_fifo_full(1),
//   !adc_fifo_empty(2), using 1-cycle delayed copies. Clear by writing 1 to IRQ_PEND; set wins over
//   clear in the same cycle. slave_irq = |(pend & mask), registered.
//  Undefined: slave_irq tied 0; addr 4/5 and STATUS pend field read 0; writes ignored.
// STRUCTURE
//  Shared package codec_pkg: ADDR_* constants 0..5, STATUS bit indices, IRQ source indices,
//   burst state encodings.
//  One sub-module codec_burst_ctrl: FSM + bCount + address latch; outputs eff_address, burst_active.
// TESTING
//  Write 0x00341E05 to addr0, i2c_idle=1 -> i2c_start 1 cycle, i2c_packet=0x341E05.
//  dac_fifo_full=1, write addr2 0xAAAA5555 -> waitrequest held, no dac_wr; full->0 -> dac_wr 1 cycle.
//  Read burst addr3, burstcount=4, adc_fifo_empty toggling -> exactly 4 adc_rd, FSM returns IDLE.
//  Write burst count 3 with slave_address changing mid-burst -> all 3 beats go to latched addr2.
//  IRQ: mask=0b100, adc_fifo_empty 1->0 -> slave_irq=1; write 0b100 to addr5 -> slave_irq=0.
//  Assert Rst mid-burst (bCount=2) -> IDLE, bCount 0, all outputs 0; next beginburst accepted.

Source files
------------

// File: rtl/codec_pkg.sv
// ---------------------------------------------------------------------------
// codec_pkg
// Shared constants for the WM8731 codec Avalon-MM register interface:
// register word addresses, STATUS bit positions, interrupt source indices
// and the burst controller state encoding.
// ---------------------------------------------------------------------------
package codec_pkg;

  // Register word addresses on slave_address
  localparam logic [2:0] ADDR_I2C_CMD  = 3'd0;
  localparam logic [2:0] ADDR_STATUS   = 3'd1;
  localparam logic [2:0] ADDR_DAC      = 3'd2;
  localparam logic [2:0] ADDR_ADC      = 3'd3;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd4;
  localparam logic [2:0] ADDR_IRQ_PEND = 3'd5;

  // Bit positions inside the STATUS word
  localparam int STAT_I2C_IDLE  = 0;
  localparam int STAT_DAC_FULL  = 1;
  localparam int STAT_ADC_EMPTY = 2;
  localparam int STAT_PEND_LSB  = 3;

  // Interrupt sources, one pending/mask bit each
  localparam int IRQ_I2C_IDLE  = 0;
  localparam int IRQ_DAC_READY = 1;
  localparam int IRQ_ADC_AVAIL = 2;
  localparam int NUM_IRQ       = 3;

  // Burst controller states
  typedef enum logic [1:0] {
    BURST_IDLE = 2'd0,
    BURST_RD   = 2'd1,
    BURST_WR   = 2'd2
  } burst_state_t;

endpackage

// File: rtl/codec_burst_ctrl.sv
// ---------------------------------------------------------------------------
// codec_burst_ctrl
// Tracks fixed-address Avalon bursts. On the first beat the address is
// latched and the beat count loaded; while a burst is running the latched
// address replaces slave_address so every beat reaches the same FIFO.
// Ports:
//   Clk, Rst        clock, asynchronous active-high reset
//   burst_begin     first beat of a burst with exactly one strobe
//   burst_is_read   direction of that first beat
//   burstcount      number of beats in the burst (0 = no burst)
//   slave_address   address presented by the master
//   beat_accepted   the current beat completes this cycle
//   eff_address     address the register map decodes
//   burst_active    a burst is in progress (RD or WR state)
// ---------------------------------------------------------------------------
module codec_burst_ctrl
  import codec_pkg::*;
#(
  parameter int BURST_W = 8
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               burst_begin,
  input  logic               burst_is_read,
  input  logic [BURST_W-1:0] burstcount,
  input  logic [2:0]         slave_address,
  input  logic               beat_accepted,
  output logic [2:0]         eff_address,
  output logic               burst_active
);

  localparam logic [BURST_W-1:0] COUNT_ONE = BURST_W'(1);

  burst_state_t       state, state_next;
  logic [BURST_W-1:0] b_count, b_count_next;
  logic [2:0]         lat_address, lat_address_next;

  // State, remaining-beat counter and latched address registers
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state       <= BURST_IDLE;
      b_count     <= '0;
      lat_address <= '0;
    end else begin
      state       <= state_next;
      b_count     <= b_count_next;
      lat_address <= lat_address_next;
    end
  end

  // Next-state logic. The first beat counts toward the burst, so a burst
  // whose first beat is accepted immediately loads burstcount-1, and a
  // single-beat burst never leaves IDLE. Stalled beats do not count.
  always_comb begin
    state_next       = state;
    b_count_next     = b_count;
    lat_address_next = lat_address;
    case (state)
      BURST_IDLE: begin
        if (burst_begin && (burstcount != '0)) begin
          lat_address_next = slave_address;
          if (!beat_accepted) begin
            state_next   = burst_is_read ? BURST_RD : BURST_WR;
            b_count_next = burstcount;
          end else if (burstcount != COUNT_ONE) begin
            state_next   = burst_is_read ? BURST_RD : BURST_WR;
            b_count_next = burstcount - COUNT_ONE;
          end
        end
      end
      BURST_RD, BURST_WR: begin
        if (beat_accepted) begin
          if (b_count == COUNT_ONE) begin
            state_next   = BURST_IDLE;
            b_count_next = '0;
          end else begin
            b_count_next = b_count - COUNT_ONE;
          end
        end
      end
      default: begin
        state_next   = BURST_IDLE;
        b_count_next = '0;
      end
    endcase
  end

  // Address override while a burst is running
  assign burst_active = (state != BURST_IDLE);
  assign eff_address  = burst_active ? lat_address : slave_address;

endmodule

// File: rtl/codec_mm_slave.sv
// ---------------------------------------------------------------------------
// codec_mm_slave
// Avalon-MM slave for the WM8731 codec: I2C command register, status,
// DAC FIFO push port, ADC FIFO pop port, optional maskable sticky IRQs.
// Supports waitrequest backpressure and fixed-address bursts.
// Optional feature macro: CODEC_MM_SLAVE_IRQ_EN (IRQ mask/pending registers
// and slave_irq). Without it slave_irq is 0 and addresses 4/5 read 0.
// Ports:
//   Clk, Rst                  clock, asynchronous active-high reset
//   slave_*                   Avalon-MM slave (32-bit data, 3-bit word address)
//   slave_irq                 registered level interrupt
//   i2c_idle/i2c_start/i2c_packet   I2C master handshake and command
//   dac_fifo_full/dac_wr/dac_fifo_in  DAC FIFO push side
//   adc_fifo_empty/adc_rd/adc_fifo_out ADC show-ahead FIFO pop side
// ---------------------------------------------------------------------------
module codec_mm_slave
  import codec_pkg::*;
#(
  parameter  int SAMPLE_W = 16,
  parameter  int NUM_CH   = 2,
  parameter  int I2C_W    = 24,
  parameter  int BURST_W  = 8,
  localparam int DATA_W   = NUM_CH * SAMPLE_W
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               slave_chipselect,
  input  logic               slave_read,
  input  logic               slave_write,
  input  logic [2:0]         slave_address,
  input  logic [31:0]        slave_writedata,
  output logic [31:0]        slave_readdata,
  output logic               slave_waitrequest,
  input  logic               slave_beginbursttransfer,
  input  logic [BURST_W-1:0] slave_burstcount,
  output logic               slave_irq,
  input  logic               i2c_idle,
  output logic               i2c_start,
  output logic [I2C_W-1:0]   i2c_packet,
  input  logic               dac_fifo_full,
  output logic               dac_wr,
  output logic [DATA_W-1:0]  dac_fifo_in,
  input  logic               adc_fifo_empty,
  output logic               adc_rd,
  input  logic [DATA_W-1:0]  adc_fifo_out
);

  logic                single_rd, single_wr;
  logic                beat_accepted, rd_acc, wr_acc;
  logic                burst_begin, burst_active;
  logic [2:0]          eff_address;
  logic [NUM_IRQ-1:0]  mask_view, pend_view;
  logic [31:0]         status_word;

  // Access qualification. Simultaneous read and write is not an access.
  // Everything is held quiet while reset is asserted so no strobe escapes.
  always_comb begin
    single_rd = slave_chipselect & slave_read & ~slave_write & ~Rst;
    single_wr = slave_chipselect & slave_write & ~slave_read & ~Rst;
    slave_waitrequest =
        (single_wr & (((eff_address == ADDR_I2C_CMD) & ~i2c_idle) |
                      ((eff_address == ADDR_DAC) & dac_fifo_full))) |
        (single_rd & (eff_address == ADDR_ADC) & adc_fifo_empty);
    beat_accepted = (single_rd | single_wr) & ~slave_waitrequest;
    rd_acc        = beat_accepted & single_rd;
    wr_acc        = beat_accepted & single_wr;
    burst_begin   = slave_beginbursttransfer & (single_rd | single_wr) & ~burst_active;
  end

  codec_burst_ctrl #(
    .BURST_W (BURST_W)
  ) u_burst (
    .Clk           (Clk),
    .Rst           (Rst),
    .burst_begin   (burst_begin),
    .burst_is_read (single_rd),
    .burstcount    (slave_burstcount),
    .slave_address (slave_address),
    .beat_accepted (beat_accepted),
    .eff_address   (eff_address),
    .burst_active  (burst_active)
  );

  // FIFO strobes fire in the cycle the beat is accepted
  assign dac_wr      = wr_acc & (eff_address == ADDR_DAC);
  assign dac_fifo_in = slave_writedata[DATA_W-1:0];
  assign adc_rd      = rd_acc & (eff_address == ADDR_ADC);

  // I2C command register; the start pulse follows the accepted write by one
  // cycle so the packet is already stable when the master sees it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      i2c_start  <= 1'b0;
      i2c_packet <= '0;
    end else begin
      i2c_start <= wr_acc & (eff_address == ADDR_I2C_CMD);
      if (wr_acc && (eff_address == ADDR_I2C_CMD)) begin
        i2c_packet <= slave_writedata[I2C_W-1:0];
      end
    end
  end

`ifdef CODEC_MM_SLAVE_IRQ_EN
  logic [NUM_IRQ-1:0] irq_mask, irq_pend, pend_set, pend_clr;
  logic               idle_d, dac_full_d, adc_empty_d, irq_q;

  // Edge detection on the delayed copies and write-1-to-clear decode
  always_comb begin
    pend_set                = '0;
    pend_set[IRQ_I2C_IDLE]  = i2c_idle & ~idle_d;
    pend_set[IRQ_DAC_READY] = ~dac_fifo_full & dac_full_d;
    pend_set[IRQ_ADC_AVAIL] = ~adc_fifo_empty & adc_empty_d;
    pend_clr                = '0;
    if (wr_acc && (eff_address == ADDR_IRQ_PEND)) begin
      pend_clr = slave_writedata[NUM_IRQ-1:0];
    end
  end

  // Sticky pending bits (a new event beats a clear in the same cycle),
  // mask register and the registered interrupt line
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      idle_d      <= 1'b0;
      dac_full_d  <= 1'b0;
      adc_empty_d <= 1'b0;
      irq_mask    <= '0;
      irq_pend    <= '0;
      irq_q       <= 1'b0;
    end else begin
      idle_d      <= i2c_idle;
      dac_full_d  <= dac_fifo_full;
      adc_empty_d <= adc_fifo_empty;
      irq_pend    <= (irq_pend & ~pend_clr) | pend_set;
      if (wr_acc && (eff_address == ADDR_IRQ_MASK)) begin
        irq_mask <= slave_writedata[NUM_IRQ-1:0];
      end
      irq_q <= |(irq_pend & irq_mask);
    end
  end

  assign slave_irq = irq_q;
  assign mask_view = irq_mask;
  assign pend_view = irq_pend;
`else
  assign slave_irq = 1'b0;
  assign mask_view = '0;
  assign pend_view = '0;
`endif

  // Combinational read mux; the bus reads 0 unless a read beat is accepted
  always_comb begin
    status_word                                 = '0;
    status_word[STAT_I2C_IDLE]                  = i2c_idle;
    status_word[STAT_DAC_FULL]                  = dac_fifo_full;
    status_word[STAT_ADC_EMPTY]                 = adc_fifo_empty;
    status_word[STAT_PEND_LSB +: NUM_IRQ]       = pend_view;
    slave_readdata = '0;
    if (rd_acc) begin
      case (eff_address)
        ADDR_I2C_CMD:  slave_readdata = 32'(i2c_packet);
        ADDR_STATUS:   slave_readdata = status_word;
        ADDR_ADC:      slave_readdata = 32'(adc_fifo_out);
        ADDR_IRQ_MASK: slave_readdata = 32'(mask_view);
        ADDR_IRQ_PEND: slave_readdata = 32'(pend_view);
        default:       slave_readdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_mm_slave.sv
// ---------------------------------------------------------------------------
// tb_codec_mm_slave
// Self-checking bench for codec_mm_slave: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference
// model kept in this file. Honours CODEC_MM_SLAVE_IRQ_EN if defined.
// ---------------------------------------------------------------------------
module tb_codec_mm_slave;

`ifdef CODEC_MM_SLAVE_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        Clk, Rst;
  logic        slave_chipselect, slave_read, slave_write;
  logic [2:0]  slave_address;
  logic [31:0] slave_writedata, slave_readdata;
  logic        slave_waitrequest, slave_beginbursttransfer;
  logic [7:0]  slave_burstcount;
  logic        slave_irq, i2c_idle, i2c_start;
  logic [23:0] i2c_packet;
  logic        dac_fifo_full, dac_wr;
  logic [31:0] dac_fifo_in;
  logic        adc_fifo_empty, adc_rd;
  logic [31:0] adc_fifo_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_adc_rd = 0;
  int n_dac_wr = 0;

  // Reference model state: beats left in the current burst and its address,
  // last I2C command, pending start pulse, IRQ registers and previous inputs
  int          m_left;
  logic [2:0]  m_addr;
  logic [23:0] m_pkt;
  logic        m_start, m_irq;
  logic [2:0]  m_mask, m_pend;
  logic        p_idle, p_full, p_empty;

  codec_mm_slave dut (
    .Clk                      (Clk),
    .Rst                      (Rst),
    .slave_chipselect         (slave_chipselect),
    .slave_read               (slave_read),
    .slave_write              (slave_write),
    .slave_address            (slave_address),
    .slave_writedata          (slave_writedata),
    .slave_readdata           (slave_readdata),
    .slave_waitrequest        (slave_waitrequest),
    .slave_beginbursttransfer (slave_beginbursttransfer),
    .slave_burstcount         (slave_burstcount),
    .slave_irq                (slave_irq),
    .i2c_idle                 (i2c_idle),
    .i2c_start                (i2c_start),
    .i2c_packet               (i2c_packet),
    .dac_fifo_full            (dac_fifo_full),
    .dac_wr                   (dac_wr),
    .dac_fifo_in              (dac_fifo_in),
    .adc_fifo_empty           (adc_fifo_empty),
    .adc_rd                   (adc_rd),
    .adc_fifo_out             (adc_fifo_out)
  );

  // Free-running 100 MHz clock
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_left  = 0;
    m_addr  = '0;
    m_pkt   = '0;
    m_start = 1'b0;
    m_irq   = 1'b0;
    m_mask  = '0;
    m_pend  = '0;
    p_idle  = 1'b0;
    p_full  = 1'b0;
    p_empty = 1'b0;
  endtask

  task automatic driveIdle();
    slave_chipselect = 0; slave_read = 0; slave_write = 0; slave_address = '0;
    slave_writedata = '0; slave_beginbursttransfer = 0; slave_burstcount = '0;
    i2c_idle = 0; dac_fifo_full = 0; adc_fifo_empty = 0; adc_fifo_out = '0;
  endtask

  task automatic checkQuietOutputs(input string tag);
    checkOutput({tag, "_waitrequest"}, slave_waitrequest, 0);
    checkOutput({tag, "_readdata"}, slave_readdata, 0);
    checkOutput({tag, "_i2c_start"}, i2c_start, 0);
    checkOutput({tag, "_i2c_packet"}, i2c_packet, 0);
    checkOutput({tag, "_dac_wr"}, dac_wr, 0);
    checkOutput({tag, "_adc_rd"}, adc_rd, 0);
    checkOutput({tag, "_irq"}, slave_irq, 0);
  endtask

  // One bus cycle: drive at the falling edge, compare against the model
  // mid-cycle, then advance the model to what the next rising edge produces
  task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                               input logic [2:0] addr, input logic [31:0] wd,
                               input logic bb, input logic [7:0] bc,
                               input logic idle, input logic full, input logic empty,
                               input logic [31:0] fout);
    logic       ro, wo, wt, acc, e_dac, e_adc;
    logic [2:0] ea, setv, clrv;
    logic [31:0] rdx;
    @(negedge Clk);
    slave_chipselect = cs; slave_read = rd; slave_write = wr; slave_address = addr;
    slave_writedata = wd; slave_beginbursttransfer = bb; slave_burstcount = bc;
    i2c_idle = idle; dac_fifo_full = full; adc_fifo_empty = empty; adc_fifo_out = fout;
    #2;
    checkOutput("i2c_start", i2c_start, m_start);
    checkOutput("i2c_packet", i2c_packet, m_pkt);
    checkOutput("slave_irq", slave_irq, m_irq);

    ro = cs & rd & ~wr;
    wo = cs & wr & ~rd;
    ea = (m_left > 0) ? m_addr : addr;
    wt = (wo & ((ea == 3'd0 && !idle) || (ea == 3'd2 && full))) | (ro & ea == 3'd3 & empty);
    acc = (ro | wo) & ~wt;
    rdx = '0;
    if (acc && ro) begin
      case (ea)
        3'd0: rdx = {8'h00, m_pkt};
        3'd1: rdx = {26'd0, m_pend, empty, full, idle};
        3'd3: rdx = fout;
        3'd4: rdx = {29'd0, m_mask};
        3'd5: rdx = {29'd0, m_pend};
        default: rdx = '0;
      endcase
    end
    e_dac = acc & wo & (ea == 3'd2);
    e_adc = acc & ro & (ea == 3'd3);
    checkOutput("waitrequest", slave_waitrequest, wt);
    checkOutput("readdata", slave_readdata, rdx);
    checkOutput("dac_wr", dac_wr, e_dac);
    checkOutput("adc_rd", adc_rd, e_adc);
    if (e_dac) checkOutput("dac_fifo_in", dac_fifo_in, wd);
    n_adc_rd += int'(adc_rd);
    n_dac_wr += int'(dac_wr);

    if (m_left == 0) begin
      if (cs && bb && (ro || wo) && bc != 0) begin
        m_addr = addr;
        m_left = int'(bc) - (acc ? 1 : 0);
      end
    end else if (acc) begin
      m_left--;
    end
    m_start = acc & wo & (ea == 3'd0);
    if (m_start) m_pkt = wd[23:0];
`ifdef CODEC_MM_SLAVE_IRQ_EN
    m_irq = |(m_pend & m_mask);
    setv = {p_empty & ~empty, p_full & ~full, idle & ~p_idle};
    clrv = (acc && wo && ea == 3'd5) ? wd[2:0] : 3'b000;
    m_pend = (m_pend & ~clrv) | setv;
    if (acc && wo && ea == 3'd4) m_mask = wd[2:0];
    p_idle = idle; p_full = full; p_empty = empty;
`else
    setv = '0;
    clrv = '0;
`endif
  endtask

  initial begin
    int base;
    logic [2:0] burst_addrs [7];
    logic       burst_empty [7];
    burst_addrs = '{3'd3, 3'd0, 3'd1, 3'd5, 3'd0, 3'd1, 3'd6};
    burst_empty = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset state
    Rst = 1'b1;
    driveIdle();
    modelReset();
    repeat (3) @(posedge Clk);
    #1;
    checkQuietOutputs("reset");
    @(negedge Clk);
    Rst = 1'b0;

    // I2C command write with the master idle
    $display("[TB] I2C command write");
    applyStimulus(1, 0, 1, 3'd0, 32'h00341E05, 0, 0, 1, 0, 1, 0);
    @(posedge Clk);
    #1;
    checkOutput("i2c_start_pulse", i2c_start, 1);
    checkOutput("i2c_packet_value", i2c_packet, 32'h00341E05);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 1, 0);

    // DAC push stalled by a full FIFO, then released
    $display("[TB] DAC backpressure");
    repeat (3) applyStimulus(1, 0, 1, 3'd2, 32'hAAAA5555, 0, 0, 1, 1, 1, 0);
    checkOutput("dac_stall_wait", slave_waitrequest, 1);
    checkOutput("dac_stall_wr", dac_wr, 0);
    applyStimulus(1, 0, 1, 3'd2, 32'hAAAA5555, 0, 0, 1, 0, 1, 0);
    checkOutput("dac_release_wr", dac_wr, 1);
    checkOutput("dac_release_data", dac_fifo_in, 32'hAAAA5555);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 1, 0);

    // ADC read burst of 4 with the FIFO going empty between beats and the
    // master address wandering; every beat must pop the ADC FIFO
    $display("[TB] ADC read burst");
    base = n_adc_rd;
    for (int i = 0; i < 7; i++)
      applyStimulus(1, 1, 0, burst_addrs[i], 0, (i == 0), 8'd4, 1, 0, burst_empty[i], $urandom);
    checkOutput("adc_burst_pops", n_adc_rd - base, 4);
    applyStimulus(1, 1, 0, 3'd0, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("post_burst_addr0", slave_readdata, 32'h00341E05);
    checkOutput("post_burst_no_pop", adc_rd, 0);

    // DAC write burst of 3 with the address changing mid-burst
    $display("[TB] DAC write burst");
    base = n_dac_wr;
    applyStimulus(1, 0, 1, 3'd2, $urandom, 1, 8'd3, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 3'd6, $urandom, 0, 8'd0, 0, 0, 1, 0);
    applyStimulus(1, 0, 1, 3'd0, $urandom, 0, 8'd0, 0, 0, 1, 0);
    checkOutput("dac_burst_pushes", n_dac_wr - base, 3);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 1, 0);

    // ADC-available interrupt: mask source 2, raise it, then clear it
    $display("[TB] interrupt set and clear");
    applyStimulus(1, 0, 1, 3'd4, 32'h4, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("irq_raised", slave_irq, IRQ_ON);
    applyStimulus(1, 0, 1, 3'd5, 32'h4, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("irq_cleared", slave_irq, 0);

    // Reset in the middle of a write burst with two beats left
    $display("[TB] reset mid-burst");
    applyStimulus(1, 0, 1, 3'd2, $urandom, 1, 8'd4, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 3'd7, $urandom, 0, 8'd0, 1, 0, 0, 0);
    @(negedge Clk);
    Rst = 1'b1;
    slave_address = 3'd0;
    i2c_idle = 1'b0;
    #2;
    checkQuietOutputs("midreset");
    @(negedge Clk);
    driveIdle();
    modelReset();
    @(negedge Clk);
    Rst = 1'b0;
    base = n_adc_rd;
    applyStimulus(1, 1, 0, 3'd3, 0, 1, 8'd2, 0, 0, 0, $urandom);
    applyStimulus(1, 1, 0, 3'd1, 0, 0, 8'd0, 0, 0, 0, $urandom);
    checkOutput("post_reset_burst", n_adc_rd - base, 2);
    applyStimulus(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic against the model
    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), 3'($urandom),
                    $urandom, $urandom_range(0, 4) == 0, 8'($urandom_range(0, 4)),
                    1'($urandom), 1'($urandom), 1'($urandom), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
